// File: rtl/dsm_pkg.sv
// Shared delta-sigma definitions: CIC accumulator width growth, bit-to-level mapping
// and the scaling shift, used by both the modulator and the demodulator ends.
package dsm_pkg;

   localparam int PLUS_ONE  = 1;
   localparam int MINUS_ONE = -1;

   // Worst-case CIC growth is ORDER*log2(DECIM) bits; two extra bits cover the sign and the +/-1 input.
   function automatic int cicAccWidth(input int order, input int decim);
      return order * $clog2(decim) + 2;
   endfunction

   function automatic int cicShift(input int accWidth, input int dataWidth);
      return accWidth - dataWidth;
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator (differential delay 1) running at the decimated rate;
// the delay register only advances on the enable strike.
module cic_comb_stage #(
   parameter int WIDTH = 20
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_y
);

   logic [WIDTH-1:0] delay_q;
   logic [WIDTH-1:0] delay_d;

   always_comb begin
      delay_d = delay_q;
      if (i_en) delay_d = i_x;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) delay_q <= '0;
      else          delay_q <= delay_d;
   end

   assign o_y = i_x - delay_q;

endmodule

// File: rtl/dsm_cic_decimator.sv
// Sinc^ORDER CIC decimator turning the 1-bit modulator stream into signed PCM with a
// valid/ready output. Define DSM_DECIM_ROUND_EN for round-half-up with positive saturation.
module dsm_cic_decimator
   import dsm_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ORDER      = 3,
   parameter int DECIM      = 64,
   parameter int ACC_WIDTH  = cicAccWidth(ORDER, DECIM)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_overrun
);

   localparam int CNT_W = $clog2(DECIM);
   localparam int SHIFT = cicShift(ACC_WIDTH, DATA_WIDTH);

   logic [ACC_WIDTH-1:0] inBit;
   logic [ACC_WIDTH-1:0] integ_q [ORDER];
   logic [CNT_W-1:0]     decimCnt_q;
   logic                 strike;

   assign inBit  = i_data ? ACC_WIDTH'(PLUS_ONE) : ACC_WIDTH'(MINUS_ONE);
   assign strike = i_en && (decimCnt_q == CNT_W'(DECIM - 1));

   // Integrators wrap modulo 2^ACC_WIDTH; the combs cancel the wrap exactly.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
         decimCnt_q <= '0;
      end else if (i_en) begin
         integ_q[0] <= integ_q[0] + inBit;
         for (int k = 1; k < ORDER; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
         decimCnt_q <= decimCnt_q + CNT_W'(1);
      end
   end

   logic [ACC_WIDTH-1:0] combChain [ORDER+1];

   assign combChain[0] = integ_q[ORDER-1];

   for (genvar g = 0; g < ORDER; g++) begin : gComb
      cic_comb_stage #(
         .WIDTH(ACC_WIDTH)
      ) uComb (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .i_en   (strike),
         .i_x    (combChain[g]),
         .o_y    (combChain[g+1])
      );
   end

   logic signed [ACC_WIDTH-1:0]  combRes;
   logic        [DATA_WIDTH-1:0] scaled;

   assign combRes = combChain[ORDER];

`ifdef DSM_DECIM_ROUND_EN
   localparam logic signed [ACC_WIDTH:0] ROUND_INC =
      (SHIFT > 0) ? (ACC_WIDTH+1)'(64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_WIDTH:0] SAT_MAX =
      (ACC_WIDTH+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);

   logic signed [ACC_WIDTH:0] rounded;
   logic signed [ACC_WIDTH:0] roundShift;

   // The increment is positive, so only the positive rail can overflow.
   always_comb begin
      rounded    = $signed({combRes[ACC_WIDTH-1], combRes}) + ROUND_INC;
      roundShift = rounded >>> SHIFT;
      scaled     = DATA_WIDTH'(roundShift);
      if (roundShift > SAT_MAX) scaled = DATA_WIDTH'(SAT_MAX);
   end
`else
   always_comb begin
      scaled = DATA_WIDTH'(combRes >>> SHIFT);
   end
`endif

   logic [DATA_WIDTH-1:0] oData_q, oData_d;
   logic                  oValid_q, oValid_d;
   logic                  oOverrun_q, oOverrun_d;

   // A fresh sample always wins; it only counts as an overrun if the old one was not taken.
   always_comb begin
      oData_d    = oData_q;
      oValid_d   = oValid_q;
      oOverrun_d = 1'b0;
      if (strike) begin
         oData_d    = scaled;
         oValid_d   = 1'b1;
         oOverrun_d = oValid_q && !i_ready;
      end else if (oValid_q && i_ready) begin
         oValid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         oData_q    <= '0;
         oValid_q   <= 1'b0;
         oOverrun_q <= 1'b0;
      end else begin
         oData_q    <= oData_d;
         oValid_q   <= oValid_d;
         oOverrun_q <= oOverrun_d;
      end
   end

   assign o_data    = oData_q;
   assign o_valid   = oValid_q;
   assign o_overrun = oOverrun_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Self-checking bench for dsm_cic_decimator: directed table rows, handshake/reset corner
// sequences and random bitstreams scored against an FIR-form sinc^ORDER reference.
module tb_dsm_cic_decimator;

   localparam int DATA_WIDTH = 16;
   localparam int ORDER      = 3;
   localparam int DECIM      = 64;
   localparam int SHIFT      = ORDER * $clog2(DECIM) + 2 - DATA_WIDTH;
   localparam int HLEN       = ORDER * (DECIM - 1) + 1;
   localparam int XMAX       = 32768;

   logic                  clk;
   logic                  rst_n;
   logic                  i_en;
   logic                  i_data;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  o_overrun;

   dsm_cic_decimator #(
      .DATA_WIDTH(DATA_WIDTH),
      .ORDER     (ORDER),
      .DECIM     (DECIM)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_en     (i_en),
      .i_data   (i_data),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_overrun(o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;
   int strikeCount = 0;
   int overrunCount = 0;
   int sbChecks    = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: impulse response of ORDER cascaded length-DECIM boxcars.
   int h [HLEN];
   initial begin
      int tmp [HLEN];
      int len;
      for (int j = 0; j < HLEN; j++) h[j] = (j < DECIM) ? 1 : 0;
      len = DECIM;
      for (int s = 1; s < ORDER; s++) begin
         for (int j = 0; j < HLEN; j++) tmp[j] = 0;
         for (int a = 0; a < len; a++)
            for (int b = 0; b < DECIM; b++) tmp[a+b] += h[a];
         len = len + DECIM - 1;
         for (int j = 0; j < HLEN; j++) h[j] = tmp[j];
      end
   end

   function automatic int scaleRef(input int y);
      int r;
`ifdef DSM_DECIM_ROUND_EN
      r = (y + (1 <<< (SHIFT - 1))) >>> SHIFT;
      if (r > 32767) r = 32767;
`else
      r = y >>> SHIFT;
`endif
      return r;
   endfunction

   int xs [XMAX];
   int nStrobe = 0;
   int expQ [$];

   // Model: output at strike bit t is the FIR sum over bits t-ORDER-j, zero history before reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         nStrobe = 0;
         expQ.delete();
      end else if (i_en) begin
         if (nStrobe < XMAX) xs[nStrobe] = i_data ? 1 : -1;
         if ((nStrobe % DECIM) == DECIM - 1) begin
            int y;
            y = 0;
            for (int j = 0; j < HLEN; j++) begin
               int k;
               k = nStrobe - ORDER - j;
               if (k >= 0 && k < XMAX) y += h[j] * xs[k];
            end
            expQ.push_back(scaleRef(y));
            strikeCount++;
         end
         nStrobe++;
      end
   end

   // Scoreboard: an overrun drops the oldest pending sample; every transfer is checked.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_overrun) begin
            overrunCount++;
            if (expQ.size() > 0) void'(expQ.pop_front());
         end
         if (o_valid && i_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("scoreboard_empty", 1, 0);
            end else begin
               checkOutput("scoreboard_data", int'($signed(o_data)), expQ.pop_front());
               sbChecks++;
            end
         end
      end
   end

   task automatic applyStimulus(input bit en, input bit d, input bit rdy);
      @(posedge clk);
      #1;
      i_en    = en;
      i_data  = d;
      i_ready = rdy;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      i_en    = 1'b0;
      i_data  = 1'b0;
      i_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      string name;
      int    pattern;
      bit    enToggle;
      int    expData;
      int    expPeriod;
   } rowT;

   rowT rows [4];

   initial begin
      int loads, cyc, strobeIdx, lastCyc, period, ovBase, s0, lowCnt, guard;
      bit en, d, hit;

      rows[0] = '{"const_ones",  0, 1'b0,  16384,  64};
      rows[1] = '{"const_zeros", 1, 1'b0, -16384,  64};
      rows[2] = '{"alternating", 2, 1'b0,      0,  64};
      rows[3] = '{"en_toggle",   0, 1'b1,  16384, 128};

      rst_n = 1'b1; i_en = 1'b0; i_data = 1'b0; i_ready = 1'b1;
      #2 rst_n = 1'b0;
      #20;
      checkOutput("reset_valid",   int'(o_valid),   0);
      checkOutput("reset_data",    int'(o_data),    0);
      checkOutput("reset_overrun", int'(o_overrun), 0);

      foreach (rows[r]) begin
         doReset();
         ovBase = overrunCount;
         loads = 0; cyc = 0; strobeIdx = 0; lastCyc = 0; period = 0;
         while (loads < 8 && cyc < 2000) begin
            en = rows[r].enToggle ? (cyc % 2 == 0) : 1'b1;
            case (rows[r].pattern)
               0:       d = 1'b1;
               1:       d = 1'b0;
               default: d = (strobeIdx % 2 == 0);
            endcase
            applyStimulus(en, d, 1'b1);
            if (en) strobeIdx++;
            cyc++;
            if (o_valid) begin
               loads++;
               if (loads >= 2) period = cyc - lastCyc;
               lastCyc = cyc;
               if (loads >= 5) checkOutput({rows[r].name, "_data"}, int'($signed(o_data)), rows[r].expData);
            end
         end
         checkOutput({rows[r].name, "_loads"},   loads,  8);
         checkOutput({rows[r].name, "_period"},  period, rows[r].expPeriod);
         checkOutput({rows[r].name, "_overrun"}, overrunCount - ovBase, 0);
      end

      // Overrun: hold off the consumer across two strikes.
      s0 = strikeCount; guard = 0;
      while (strikeCount == s0 && guard < 300) begin applyStimulus(1'b1, 1'b1, 1'b1); guard++; end
      applyStimulus(1'b1, 1'b1, 1'b0);
      s0 = strikeCount; ovBase = overrunCount; guard = 0; lowCnt = 0;
      while (strikeCount < s0 + 2 && guard < 300) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         guard++;
         if (strikeCount > s0 && !o_valid) lowCnt++;
      end
      checkOutput("ovr_strikes",     strikeCount - s0, 2);
      checkOutput("ovr_valid_held",  lowCnt, 0);
      checkOutput("ovr_pulse",       int'(o_overrun), 1);
      checkOutput("ovr_valid",       int'(o_valid), 1);
      checkOutput("ovr_data",        int'($signed(o_data)), 16384);
      i_ready = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("ovr_valid_drop",  int'(o_valid), 0);
      checkOutput("ovr_pulse_end",   int'(o_overrun), 0);
      checkOutput("ovr_count",       overrunCount - ovBase, 1);

      // Mid-stream reset with a pending sample.
      s0 = strikeCount; guard = 0;
      while (strikeCount == s0 && guard < 300) begin applyStimulus(1'b1, 1'b1, 1'b0); guard++; end
      checkOutput("rst_pending", int'(o_valid), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_valid_now", int'(o_valid), 0);
      checkOutput("rst_data_now",  int'(o_data),  0);
      @(posedge clk);
      #1;
      rst_n = 1'b1; i_en = 1'b1; i_data = 1'b1; i_ready = 1'b1;
      lowCnt = 0; hit = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         @(posedge clk);
         #1;
         if (c < 64 && o_valid) lowCnt++;
         if (c == 64) hit = o_valid;
      end
      checkOutput("rst_early_valid", lowCnt, 0);
      checkOutput("rst_first_valid", int'(hit), 1);

      // Random bitstreams with varying density, random strobes and back-pressure.
      begin
         int p;
         p = 50;
         for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) p = $urandom_range(5, 95);
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 99) < p, $urandom_range(0, 3) != 0);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("sb_active", int'(sbChecks > 40), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
